// File: rtl/xbi_usr_pkt_writer.sv
// User-side packetizer for the 16-bit crossbar interface write port.
// Optional max-length truncation is built when XBI_USR_LEN_CHECK_EN is defined.
module xbi_usr_pkt_writer #(
  parameter int VC0_MAX_WORDS = 12,
  parameter int VC1_MAX_WORDS = 64,
  parameter int VC2_MAX_WORDS = 64
) (
  input  logic        clk_usr,
  input  logic        rst_usr_n,
  input  logic        i_valid,
  input  logic [1:0]  i_vc,
  input  logic [15:0] i_data,
  input  logic        i_last,
  output logic        o_ready,
  input  logic [2:0]  i_nout_full,
  output logic [2:0]  o_nout_enq,
  output logic [5:0]  o_nout_offset,
  output logic        o_nout_eop,
  output logic [15:0] o_nout_data,
  output logic        o_err_len,
  output logic        o_err_vc,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  cur_vc_q, cur_vc_d;
  logic        gap_q;
  logic [1:0]  last_vc_q;

  logic        vld_p0;
  logic [1:0]  vc_p0;
  logic [5:0]  off_p0;
  logic        eop_p0;
  logic        err_len_p0, err_vc_p0;
  logic [3:0]  full_pad;
  logic        vc_ill, can_start, accept;

  logic [2:0]  enq_p1;
  logic [5:0]  off_p1;
  logic        eop_p1;
  logic [15:0] data_p1;
  logic        err_len_p1, err_vc_p1;

`ifdef XBI_USR_LEN_CHECK_EN
  function automatic logic [6:0] max_words(input logic [1:0] vc);
    case (vc)
      2'd0:    return 7'(VC0_MAX_WORDS);
      2'd1:    return 7'(VC1_MAX_WORDS);
      default: return 7'(VC2_MAX_WORDS);
    endcase
  endfunction
`else
  logic len_cfg_unused;
  assign len_cfg_unused = ^{cnt_q[6], 7'(VC0_MAX_WORDS), 7'(VC1_MAX_WORDS), 7'(VC2_MAX_WORDS)};
`endif

  always_comb begin
    full_pad   = {1'b0, i_nout_full};
    vc_ill     = (i_vc == 2'd3);
    // Same-VC start is held off one cycle after eop until the full flag catches up.
    can_start  = !vc_ill && !full_pad[i_vc] && !(gap_q && (i_vc == last_vc_q));
    o_ready    = (state_q == IDLE) ? (can_start || vc_ill) : 1'b1;
    accept     = i_valid && o_ready;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_vc_d   = cur_vc_q;
    vld_p0     = 1'b0;
    vc_p0      = cur_vc_q;
    off_p0     = 6'd0;
    eop_p0     = 1'b0;
    err_len_p0 = 1'b0;
    err_vc_p0  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (vc_ill) begin
            err_vc_p0 = 1'b1;
            if (!i_last) state_d = DROP;
          end else begin
            vld_p0   = 1'b1;
            vc_p0    = i_vc;
            eop_p0   = i_last;
            cur_vc_d = i_vc;
            cnt_d    = 7'd1;
            if (!i_last) state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          vld_p0 = 1'b1;
          off_p0 = cnt_q[5:0];
          cnt_d  = cnt_q + 7'd1;
          if (i_last) begin
            eop_p0  = 1'b1;
            state_d = IDLE;
          end
`ifdef XBI_USR_LEN_CHECK_EN
          else if (cnt_q == max_words(cur_vc_q) - 7'd1) begin
            eop_p0     = 1'b1;
            err_len_p0 = 1'b1;
            state_d    = DROP;
          end
`endif
        end
      end
      DROP: begin
        if (accept && i_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- p0 -> p1 register boundary: write port and error pulses ----
  always_ff @(posedge clk_usr or negedge rst_usr_n) begin
    if (!rst_usr_n) begin
      state_q    <= IDLE;
      cnt_q      <= 7'd0;
      cur_vc_q   <= 2'd0;
      gap_q      <= 1'b0;
      last_vc_q  <= 2'd0;
      enq_p1     <= 3'd0;
      off_p1     <= 6'd0;
      eop_p1     <= 1'b0;
      data_p1    <= 16'd0;
      err_len_p1 <= 1'b0;
      err_vc_p1  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_vc_q   <= cur_vc_d;
      gap_q      <= eop_p0;
      if (eop_p0) last_vc_q <= vc_p0;
      enq_p1     <= vld_p0 ? (3'b001 << vc_p0) : 3'b000;
      eop_p1     <= eop_p0;
      err_len_p1 <= err_len_p0;
      err_vc_p1  <= err_vc_p0;
      if (vld_p0) begin
        off_p1  <= off_p0;
        data_p1 <= i_data;
      end
    end
  end

  assign o_nout_enq    = enq_p1;
  assign o_nout_offset = off_p1;
  assign o_nout_eop    = eop_p1;
  assign o_nout_data   = data_p1;
  assign o_err_len     = err_len_p1;
  assign o_err_vc      = err_vc_p1;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_xbi_usr_pkt_writer.sv
// Scoreboard bench for xbi_usr_pkt_writer: packet-level reference model feeds
// expected writes/error pulses into queues that a negedge monitor drains.
module tb_xbi_usr_pkt_writer;

  logic        clk_usr = 1'b0;
  logic        rst_usr_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_vc = 2'd0;
  logic [15:0] i_data = 16'd0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic [2:0]  i_nout_full = 3'd0;
  logic [2:0]  o_nout_enq;
  logic [5:0]  o_nout_offset;
  logic        o_nout_eop;
  logic [15:0] o_nout_data;
  logic        o_err_len;
  logic        o_err_vc;
  logic        o_busy;

`ifdef XBI_USR_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  xbi_usr_pkt_writer dut (
    .clk_usr(clk_usr), .rst_usr_n(rst_usr_n),
    .i_valid(i_valid), .i_vc(i_vc), .i_data(i_data), .i_last(i_last),
    .o_ready(o_ready), .i_nout_full(i_nout_full),
    .o_nout_enq(o_nout_enq), .o_nout_offset(o_nout_offset),
    .o_nout_eop(o_nout_eop), .o_nout_data(o_nout_data),
    .o_err_len(o_err_len), .o_err_vc(o_err_vc), .o_busy(o_busy)
  );

  always #5 clk_usr = ~clk_usr;

  int cyc = 0;
  always @(posedge clk_usr) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [2:0]  enq;
    logic [5:0]  off;
    logic        eop;
    logic [15:0] data;
  } wr_t;
  typedef struct {
    int   at;
    logic len;
    logic vce;
  } er_t;

  wr_t wq[$];
  er_t eq[$];
  int  checks = 0;
  int  errors = 0;
  int  last_eop_edge = -10;
  logic [1:0] last_eop_vc = 2'd0;
  logic exp_busy = 1'b0;

  function automatic int max_words(input logic [1:0] vc);
    if (vc == 2'd0) return 12;
    return 64;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT write / error pulse must match the head of its queue.
  always @(negedge clk_usr) begin
    if (rst_usr_n) begin
      if (o_nout_enq != 3'd0) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual_enq=%0h expected_enq=0 cyc=%0d", o_nout_enq, cyc);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_cycle", cyc, w.at);
          chk("wr_enq", {29'd0, o_nout_enq}, {29'd0, w.enq});
          chk("wr_offset", {26'd0, o_nout_offset}, {26'd0, w.off});
          chk("wr_eop", {31'd0, o_nout_eop}, {31'd0, w.eop});
          chk("wr_data", {16'd0, o_nout_data}, {16'd0, w.data});
        end
      end
      if (o_err_len || o_err_vc) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err actual_len=%0b actual_vc=%0b expected=none cyc=%0d", o_err_len, o_err_vc, cyc);
        end else begin
          er_t e;
          e = eq.pop_front();
          chk("err_cycle", cyc, e.at);
          chk("err_len", {31'd0, o_err_len}, {31'd0, e.len});
          chk("err_vc", {31'd0, o_err_vc}, {31'd0, e.vce});
        end
      end
    end
  end

  // Reference model: what one accepted word of a packet must produce.
  task automatic model_word(input logic [1:0] vc, input int n, input int i, input logic [15:0] d);
    int e;
    int lim;
    logic eop;
    e = cyc + 1;
    if (vc == 2'd3) begin
      if (i == 0) eq.push_back('{e, 1'b0, 1'b1});
    end else begin
      lim = LEN_CHK ? max_words(vc) : 1 << 30;
      if (i < lim) begin
        eop = (i == n - 1) || (i == lim - 1);
        wq.push_back('{e, 3'(1 << vc), 6'(i % 64), eop, d});
        if (eop) begin
          last_eop_edge = e;
          last_eop_vc = vc;
        end
        if (i == lim - 1 && n > lim) eq.push_back('{e, 1'b1, 1'b0});
      end
    end
    exp_busy = (i != n - 1);
  endtask

  function automatic logic [2:0] rnd_full();
    return {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
  endfunction

  task automatic idle(input int k, input bit rnd);
    for (int c = 0; c < k; c++) begin
      @(negedge clk_usr);
      i_valid = 1'b0;
      i_last = 1'b0;
      i_nout_full = rnd ? rnd_full() : 3'd0;
      #1;
      chk("busy_idle", {31'd0, o_busy}, {31'd0, exp_busy});
    end
  endtask

  // Sends the first nsend words of an n-word packet; block = cycles all-full before start.
  task automatic send_pkt(input logic [1:0] vc, input int n, input int nsend, input bit rnd,
                          input int block, input logic [15:0] base);
    for (int i = 0; i < nsend; i++) begin
      int waitc;
      bit done;
      logic exp_rdy;
      logic [3:0] f4;
      waitc = 0;
      done = 1'b0;
      if (rnd && $urandom_range(0, 3) == 0) idle(1, 1'b1);
      while (!done) begin
        @(negedge clk_usr);
        i_valid = 1'b1;
        i_vc = (i == 0) ? vc : 2'($urandom);
        i_data = rnd ? 16'($urandom) : base + 16'(i);
        i_last = (i == n - 1);
        if (rnd) i_nout_full = rnd_full();
        else i_nout_full = (block > 0 && (i > 0 || waitc < block)) ? 3'b111 : 3'b000;
        #1;
        f4 = {1'b0, i_nout_full};
        exp_rdy = (i != 0) || (vc == 2'd3) ||
                  (!f4[vc] && !(cyc == last_eop_edge && vc == last_eop_vc));
        chk("ready", {31'd0, o_ready}, {31'd0, exp_rdy});
        chk("busy", {31'd0, o_busy}, {31'd0, exp_busy});
        if (exp_rdy) begin
          model_word(vc, n, i, i_data);
          done = 1'b1;
        end else begin
          waitc++;
          if (waitc > 300) begin
            checks++; errors++;
            $display("FAIL start_timeout actual=not_ready expected=accept vc=%0d", vc);
            i_valid = 1'b0;
            return;
          end
        end
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_enq", {29'd0, o_nout_enq}, 32'd0);
    chk("rst_offset", {26'd0, o_nout_offset}, 32'd0);
    chk("rst_eop", {31'd0, o_nout_eop}, 32'd0);
    chk("rst_data", {16'd0, o_nout_data}, 32'd0);
    chk("rst_err_len", {31'd0, o_err_len}, 32'd0);
    chk("rst_err_vc", {31'd0, o_err_vc}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk_usr);
    @(negedge clk_usr);
    rst_usr_n = 1'b1;

    send_pkt(2'd1, 5, 5, 1'b0, 0, 16'hA000);
    idle(3, 1'b0);
    send_pkt(2'd0, 3, 3, 1'b0, 4, 16'hC000);
    idle(2, 1'b0);
    send_pkt(2'd2, 2, 2, 1'b0, 0, 16'hD000);
    send_pkt(2'd2, 2, 2, 1'b0, 0, 16'hD010);
    idle(2, 1'b0);
    send_pkt(2'd0, 2, 2, 1'b0, 0, 16'hE000);
    send_pkt(2'd1, 2, 2, 1'b0, 0, 16'hE010);
    idle(2, 1'b0);
    send_pkt(2'd0, 15, 15, 1'b0, 0, 16'hF000);
    send_pkt(2'd0, 2, 2, 1'b0, 0, 16'hF100);
    idle(2, 1'b0);
    send_pkt(2'd3, 4, 4, 1'b0, 0, 16'h1000);
    send_pkt(2'd3, 1, 1, 1'b0, 0, 16'h1100);
    send_pkt(2'd1, 3, 3, 1'b0, 0, 16'h1200);
    idle(2, 1'b0);

    // Reset in the middle of a VC1 packet.
    send_pkt(2'd1, 8, 3, 1'b0, 0, 16'h7700);
    @(negedge clk_usr);
    i_valid = 1'b0;
    #2;
    chk("q_empty_before_rst", wq.size(), 32'd0);
    rst_usr_n = 1'b0;
    #1;
    chk("midrst_enq", {29'd0, o_nout_enq}, 32'd0);
    chk("midrst_offset", {26'd0, o_nout_offset}, 32'd0);
    chk("midrst_eop", {31'd0, o_nout_eop}, 32'd0);
    chk("midrst_data", {16'd0, o_nout_data}, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    exp_busy = 1'b0;
    last_eop_edge = -10;
    @(negedge clk_usr);
    rst_usr_n = 1'b1;
    send_pkt(2'd1, 4, 4, 1'b0, 0, 16'hB000);
    idle(2, 1'b0);

    for (int p = 0; p < 300; p++) begin
      logic [1:0] vc;
      int n;
      vc = 2'($urandom_range(0, 3));
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 16));
      send_pkt(vc, n, n, 1'b1, 0, 16'h0);
      if ($urandom_range(0, 4) == 0) idle(1, 1'b1);
    end

    idle(5, 1'b0);
    chk("wq_drained", wq.size(), 32'd0);
    chk("eq_drained", eq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
